// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter and the multiplier controller it feeds.
package mult_pkg;

    localparam int unsigned MULT_DW      = 8;
    localparam int unsigned MULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_ABORT = 3'd4
    } arb_state_e;

    // Operand pair as presented to the multiplier datapath
    typedef struct packed {
        logic [MULT_DW-1:0] a;
        logic [MULT_DW-1:0] b;
    } mult_op_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester bus and multiplier handshake seen by the arbiter.
interface mult_arbiter_if
    import mult_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = MULT_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] a_in;
    logic [NREQ*DW-1:0] b_in;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    rsp_valid;
    logic [2*DW-1:0]    rsp_product;
    logic               rsp_err;
    logic               m_start;
    logic [DW-1:0]      m_a;
    logic [DW-1:0]      m_b;
    logic               m_ack;
    logic               m_locked;
    logic               m_done;
    logic [2*DW-1:0]    m_product;

    modport master (
        input  req, a_in, b_in, m_ack, m_locked, m_done, m_product,
        output grant, rsp_valid, rsp_product, rsp_err, m_start, m_a, m_b
    );

    modport slave (
        output req, a_in, b_in, m_ack, m_locked, m_done, m_product,
        input  grant, rsp_valid, rsp_product, rsp_err, m_start, m_a, m_b
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            any
);
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = PW'((32'(ptr) + 32'(k)) % NREQ);
            if (!found && req[sel]) begin
                win[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between NREQ requesters, one job in flight.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = MULT_DW,
    parameter int unsigned TIMEOUT = MULT_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    mult_arbiter_if.master bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned PW = 2 * DW;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    arb_state_e      state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n, winner, winner_n, pick_idx, ptr_next;
    logic [TW-1:0]   tmo, tmo_n, tmo_inc;
    logic [NREQ-1:0] grant_q, grant_n, rsp_valid_q, rsp_valid_n, pick_oh, win_oh;
    logic            pick_any;
    logic [PW-1:0]   product_q, product_n;
    logic            err_q, err_n, start_q, start_n;
    logic [DW-1:0]   a_q, a_n, b_q, b_n;
    logic [DW-1:0]   a_arr [NREQ];
    logic [DW-1:0]   b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.a_in[i*DW +: DW];
        assign b_arr[i] = bus.b_in[i*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ), .PW(IW)) u_rr_pick (
        .req (bus.req),
        .ptr (rr_ptr),
        .win (pick_oh),
        .any (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_idx = IW'(i);
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
    end

    assign tmo_inc  = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
    assign ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            winner      <= '0;
            tmo         <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            product_q   <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            winner      <= winner_n;
            tmo         <= tmo_n;
            grant_q     <= grant_n;
            rsp_valid_q <= rsp_valid_n;
            product_q   <= product_n;
            err_q       <= err_n;
            start_q     <= start_n;
            a_q         <= a_n;
            b_q         <= b_n;
        end
    end

    // Response pulses are launched on the deciding edge so they are visible in RESP/ABORT
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        winner_n    = winner;
        tmo_n       = tmo;
        grant_n     = '0;
        rsp_valid_n = '0;
        product_n   = product_q;
        err_n       = 1'b0;
        start_n     = 1'b0;
        a_n         = a_q;
        b_n         = b_q;
        unique case (state)
            ARB_IDLE: begin
                tmo_n = '0;
                if (pick_any && !bus.m_locked) begin
                    grant_n  = pick_oh;
                    winner_n = pick_idx;
                    a_n      = a_arr[pick_idx];
                    b_n      = b_arr[pick_idx];
                    start_n  = 1'b1;
                    state_n  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.m_ack) begin
                    tmo_n   = '0;
                    state_n = ARB_WAIT;
                end else if (tmo == TMO_MAX) begin
                    rsp_valid_n = win_oh;
                    err_n       = 1'b1;
                    product_n   = '0;
                    state_n     = ARB_ABORT;
                end else begin
                    start_n = 1'b1;
                    tmo_n   = tmo_inc;
                end
            end
            ARB_WAIT: begin
                if (bus.m_done) begin
                    rsp_valid_n = win_oh;
                    product_n   = bus.m_product;
                    state_n     = ARB_RESP;
                end else if (tmo == TMO_MAX) begin
                    rsp_valid_n = win_oh;
                    err_n       = 1'b1;
                    product_n   = '0;
                    state_n     = ARB_ABORT;
                end else begin
                    tmo_n = tmo_inc;
                end
            end
            ARB_RESP, ARB_ABORT: begin
                rr_ptr_n = ptr_next;
                state_n  = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = product_q;
    assign bus.rsp_err     = err_q;
    assign bus.m_start     = start_q;
    assign bus.m_a         = a_q;
    assign bus.m_b         = b_q;

endmodule
